// File: rtl/mem_line_pkg.sv
// Shared types and address helpers for the dual-port line memory model.
package mem_line_pkg;

  localparam int WORD_SIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } d_state_t;

  // Line number of a word address: upper address bits dropped, then the
  // word-in-line bits shifted away.
  function automatic logic [31:0] line_index(input logic [31:0] addr,
                                             input int addr_bits,
                                             input int lw_bits);
    logic [31:0] mask;
    mask = (addr_bits >= 32) ? '1 : ((32'd1 << addr_bits) - 32'd1);
    return (addr & mask) >> lw_bits;
  endfunction

  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input int lw_bits);
    return addr & ((32'd1 << lw_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_line_dp_lat_pipe.sv
// Valid+data delay line; data stages only advance on valid so the output
// holds the last delivered value while idle.
module mem_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] data_reg [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_reg[k] <= '0;
      end
    end else begin
      valid_reg[0] <= in_valid;
      if (in_valid) begin
        data_reg[0] <= in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        if (valid_reg[k-1]) begin
          data_reg[k] <= data_reg[k-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/mem_line_dp.sv
// Dual-port latency memory: pipelined single-word I port, line-wide D port
// with req/done handshake. The array is stored one line per entry.
module mem_line_dp
  import mem_line_pkg::*;
#(
  parameter int    WORD_SIZE  = WORD_SIZE_DEFAULT,
  parameter int    ADDR_BITS  = 8,
  parameter int    LINE_WORDS = 4,
  parameter int    I_LATENCY  = 1,
  parameter int    D_LATENCY  = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_valid,
  output logic [WORD_SIZE-1:0]            i_rdata,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
  output logic                            d_busy,
  output logic                            d_done,
  output logic [WORD_SIZE*LINE_WORDS-1:0] d_rdata
);

  localparam int LW_BITS     = $clog2(LINE_WORDS);
  localparam int OFF_W       = (LW_BITS > 0) ? LW_BITS : 1;
  localparam int LINE_AW     = ADDR_BITS - LW_BITS;
  localparam int LINE_W      = WORD_SIZE * LINE_WORDS;
  localparam int DEPTH_LINES = 1 << LINE_AW;
  localparam int CNT_W       = $clog2(D_LATENCY + 1);

  logic [LINE_W-1:0] mem [DEPTH_LINES];

  d_state_t          state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [LINE_AW-1:0] line_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic              d_busy_reg;
  logic              d_done_reg;
  logic [LINE_W-1:0] d_rdata_reg;

  logic [LINE_AW-1:0] d_line;
  logic               accept;
  logic               commit_now;
  logic               commit_we;
  logic [LINE_AW-1:0] commit_line;
  logic [LINE_W-1:0]  commit_data;

  assign d_line = LINE_AW'(line_index(32'(d_addr), ADDR_BITS, LW_BITS));
  assign accept = (state_reg == IDLE) && d_req;

  // The commit edge is the one that enters DONE; with unit latency that is
  // the accept edge itself, so the request is taken straight from the ports.
  always_comb begin
    commit_now  = 1'b0;
    commit_we   = we_reg;
    commit_line = line_reg;
    commit_data = wdata_reg;
    if (accept && (D_LATENCY == 1)) begin
      commit_now  = reset_n;
      commit_we   = d_we;
      commit_line = d_line;
      commit_data = d_wdata;
    end else if ((state_reg == WAIT) && (cnt_reg <= CNT_W'(1))) begin
      commit_now = reset_n;
    end
  end

  always_ff @(posedge clk) begin
    if (commit_now && commit_we) begin
      mem[commit_line] <= commit_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      line_reg    <= '0;
      wdata_reg   <= '0;
      d_busy_reg  <= 1'b0;
      d_done_reg  <= 1'b0;
      d_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          d_done_reg <= 1'b0;
          if (d_req) begin
            we_reg     <= d_we;
            line_reg   <= d_line;
            wdata_reg  <= d_wdata;
            cnt_reg    <= CNT_W'(D_LATENCY - 1);
            d_busy_reg <= 1'b1;
            d_done_reg <= (D_LATENCY == 1);
            state_reg  <= (D_LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg <= CNT_W'(1)) begin
            cnt_reg    <= '0;
            d_done_reg <= 1'b1;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          d_busy_reg <= 1'b0;
          d_done_reg <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          d_busy_reg <= 1'b0;
          d_done_reg <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
      if (commit_now && !commit_we) begin
        d_rdata_reg <= mem[commit_line];
      end
    end
  end

  assign d_busy  = d_busy_reg;
  assign d_done  = d_done_reg;
  assign d_rdata = d_rdata_reg;

  // I port: a write committing on the same edge wins over the stored line.
  logic [LINE_AW-1:0]   i_line;
  logic [OFF_W-1:0]     i_off;
  logic [LINE_W-1:0]    i_line_data;
  logic [WORD_SIZE-1:0] i_words [LINE_WORDS];
  logic [WORD_SIZE-1:0] i_word;

  assign i_line = LINE_AW'(line_index(32'(i_addr), ADDR_BITS, LW_BITS));
  assign i_off  = OFF_W'(word_offset(32'(i_addr), LW_BITS));
  assign i_line_data = (commit_now && commit_we && (commit_line == i_line))
                     ? commit_data : mem[i_line];

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      assign i_words[gi] = i_line_data[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  assign i_word = i_words[i_off];

  mem_lat_pipe #(
    .DEPTH (I_LATENCY),
    .WIDTH (WORD_SIZE)
  ) u_i_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (i_req),
    .in_data   (i_word),
    .out_valid (i_valid),
    .out_data  (i_rdata)
  );

endmodule

// File: tb/tb_mem_line_dp.sv
// Bench for mem_line_dp: word-array reference model, table vectors, random
// D/I traffic, and hand sequences for forwarding, held requests and reset.
module tb_mem_line_dp;

  localparam int D_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        i_req, i_valid, d_req, d_we, d_busy, d_done;
  logic [15:0] i_addr, i_rdata, d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic        i_req1, i_valid1, d_req1, d_we1, d_busy1, d_done1;
  logic [15:0] i_addr1, i_rdata1, d_addr1;
  logic [63:0] d_wdata1, d_rdata1;

  mem_line_dp dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_busy(d_busy), .d_done(d_done), .d_rdata(d_rdata)
  );

  mem_line_dp #(.I_LATENCY(2), .D_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_valid(i_valid1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_busy(d_busy1), .d_done(d_done1), .d_rdata(d_rdata1)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m [256];
  logic [15:0] last_i;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] base_of(input logic [15:0] a);
    return (a[7:0] / 8'd4) * 8'd4;
  endfunction

  function automatic logic [63:0] model_line(input logic [15:0] a);
    logic [7:0] b;
    b = base_of(a);
    return {m[b + 8'd3], m[b + 8'd2], m[b + 8'd1], m[b]};
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [63:0] line);
    logic [7:0] b;
    b = base_of(a);
    for (int k = 0; k < 4; k++) m[b + 8'(k)] = line[k*16 +: 16];
  endtask

  task automatic check_i(input logic req, input logic [15:0] a);
    if (req) begin
      chk("i_valid", 64'(i_valid), 64'd1);
      chk("i_rdata", 64'(i_rdata), 64'(m[a[7:0]]));
      last_i = m[a[7:0]];
    end else begin
      chk("i_idle_valid", 64'(i_valid), 64'd0);
      chk("i_hold_rdata", 64'(i_rdata), 64'(last_i));
    end
  endtask

  // Called at a negedge with dut idle; random I reads run alongside.
  task automatic d_op(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                      output logic [63:0] rdata);
    int done_at, done_cnt, busy_cnt;
    logic ireq;
    logic [15:0] ia;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    ireq = 1'($urandom_range(0, 1)); ia = 16'($urandom);
    i_req = ireq; i_addr = ia;
    done_at = 0; done_cnt = 0; busy_cnt = 0; rdata = '0;
    for (int k = 1; k <= D_LAT + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        d_req = 1'b0; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = {$urandom, $urandom};
      end
      if (k == D_LAT && we) model_write(addr, wdata);
      check_i(ireq, ia);
      if (d_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        rdata = d_rdata;
      end
      if (d_busy) busy_cnt++;
      if (k == D_LAT + 2) ireq = 1'b0;
      else begin
        ireq = 1'($urandom_range(0, 1)); ia = 16'($urandom);
      end
      i_req = ireq; i_addr = ia;
    end
    chk("d_done_latency", 64'(done_at), 64'(D_LAT));
    chk("d_done_pulses", 64'(done_cnt), 64'd1);
    chk("d_busy_cycles", 64'(busy_cnt), 64'(D_LAT));
    $display("d_op we=%0d addr=%h wdata=%h rdata=%h done_at=%0d", we, addr, wdata, rdata, done_at);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [7];
    logic [63:0] rd, line_a;
    logic        ev [5];
    logic [15:0] ed [5];

    reset_n = 1'b0; last_i = '0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_i_valid", 64'(i_valid), 0);
    chk("rst_i_rdata", 64'(i_rdata), 0);
    chk("rst_d_busy", 64'(d_busy), 0);
    chk("rst_d_done", 64'(d_done), 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst1_d_busy", 64'(d_busy1), 0);
    reset_n = 1'b1;

    for (int l = 0; l < 64; l++) d_op(1'b1, 16'(l * 4), {$urandom, $urandom}, rd);

    tbl[0] = '{1'b1, 16'h0020, 64'h4444_3333_2222_1111, 64'h0};
    tbl[1] = '{1'b0, 16'h0023, 64'h0, 64'h4444_3333_2222_1111};
    tbl[2] = '{1'b1, 16'h01FE, 64'hDDDD_CCCC_BBBB_AAAA, 64'h0};
    tbl[3] = '{1'b0, 16'h00FC, 64'h0, 64'hDDDD_CCCC_BBBB_AAAA};
    tbl[4] = '{1'b1, 16'h0085, 64'h0123_4567_89AB_CDEF, 64'h0};
    tbl[5] = '{1'b0, 16'h0084, 64'h0, 64'h0123_4567_89AB_CDEF};
    tbl[6] = '{1'b0, 16'hFF87, 64'h0, 64'h0123_4567_89AB_CDEF};
    for (int v = 0; v < 7; v++) begin
      d_op(tbl[v].we, tbl[v].addr, tbl[v].wdata, rd);
      if (!tbl[v].we) chk($sformatf("table_read_%0d", v), rd, tbl[v].exp);
    end

    // I pipelining over the line written at 0x20
    for (int k = 0; k < 4; k++) begin
      i_req = 1'b1; i_addr = 16'h0020 + 16'(k);
      @(negedge clk);
      chk("ipipe_valid", 64'(i_valid), 1);
      chk("ipipe_rdata", 64'(i_rdata), 64'(16'h1111 * 16'(k + 1)));
    end
    i_req = 1'b0;
    @(negedge clk);
    chk("ipipe_idle_valid", 64'(i_valid), 0);
    chk("ipipe_hold", 64'(i_rdata), 64'h4444);
    last_i = 16'h4444;

    // Forwarding: I read of 0x31 on the commit edge of a write to line 0x30
    d_op(1'b1, 16'h0030, 64'h0000_0000_1234_0000, rd);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 64'h4444_3333_BEEF_1111;
    @(negedge clk); d_req = 1'b0;
    @(negedge clk);
    @(negedge clk); i_req = 1'b1; i_addr = 16'h0031;
    @(negedge clk); i_req = 1'b0;
    chk("fwd_i_valid", 64'(i_valid), 1);
    chk("fwd_i_rdata", 64'(i_rdata), 64'hBEEF);
    chk("fwd_d_done", 64'(d_done), 1);
    @(negedge clk);
    chk("fwd_idle_busy", 64'(d_busy), 0);
    model_write(16'h0030, 64'h4444_3333_BEEF_1111);
    last_i = 16'hBEEF;
    $display("forward i_addr=0031 i_rdata=%h", i_rdata);

    for (int r = 0; r < 40; r++) begin
      logic        we;
      logic [15:0] a;
      we = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      line_a = model_line(a);
      d_op(we, a, {$urandom, $urandom}, rd);
      if (!we) chk("rand_read", rd, line_a);
    end

    // Unit-latency instance: write, then held d_req back-to-back reads
    d_req1 = 1'b1; d_we1 = 1'b1; d_addr1 = 16'h0010; d_wdata1 = 64'hD4D4_C3C3_B2B2_A1A1;
    @(negedge clk);
    chk("u1_wr_done", 64'(d_done1), 1);
    chk("u1_wr_busy", 64'(d_busy1), 1);
    d_req1 = 1'b0;
    @(negedge clk);
    chk("u1_wr_idle", 64'(d_done1), 0);
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 16'h0012;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("u1_held_done_%0d", k), 64'(d_done1), 64'(k % 2));
      if (k % 2 == 1) chk("u1_held_rdata", d_rdata1, 64'hD4D4_C3C3_B2B2_A1A1);
      $display("held cycle=%0d d_done=%0d", k, d_done1);
    end
    d_req1 = 1'b0;
    repeat (2) @(negedge clk);

    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ed = '{16'h0, 16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hC3C3};
    for (int k = 0; k < 5; k++) begin
      i_req1 = (k < 3); i_addr1 = 16'h0010 + 16'(k);
      @(negedge clk);
      chk("u1_ipipe_valid", 64'(i_valid1), 64'(ev[k]));
      if (k >= 1) chk("u1_ipipe_rdata", 64'(i_rdata1), 64'(ed[k]));
    end
    i_req1 = 1'b0;

    // Reset in the middle of a write aborts it
    d_op(1'b1, 16'h0040, 64'h0A0A_0B0B_0C0C_0D0D, rd);
    d_op(1'b0, 16'h0040, 64'h0, rd);
    chk("rst_pre_read", rd, 64'h0A0A_0B0B_0C0C_0D0D);
    i_req = 1'b1; i_addr = 16'h0041;
    @(negedge clk);
    check_i(1'b1, 16'h0041);
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 64'hFFFF_EEEE_DDDD_CCCC;
    @(negedge clk); d_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(d_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_d_busy", 64'(d_busy), 0);
    chk("rst_mid_d_done", 64'(d_done), 0);
    chk("rst_mid_d_rdata", d_rdata, 0);
    chk("rst_mid_i_valid", 64'(i_valid), 0);
    chk("rst_mid_i_rdata", 64'(i_rdata), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1; last_i = '0;
    d_op(1'b0, 16'h0040, 64'h0, rd);
    chk("rst_abort_read", rd, 64'h0A0A_0B0B_0C0C_0D0D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
